mem_arbiter: RTL and testbench

- Arbitrates the single-port data/instruction RAM between the processor core and an external host port (program loader / debug).
- Sits between the core's memory interface and the RAM macro.
- Serialises accesses with a small FSM, uses round-robin on ties, and gives the host absolute priority while the core is halted.
- Keeps a saturating count of arbitration stalls for debug.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data/instruction RAM between the core
// and the external host port (loader/debug). Every access runs as
// IDLE -> ACCESS -> RESPOND. Simultaneous requests are resolved round-robin.
// While the core is halted the host has absolute priority.
// A saturating counter records the cycles in which a request had to wait.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_halted                  core halted; host has absolute priority
//   cpu_req/we/addr/wdata       core request (req held until cpu_ack)
//   cpu_rdata, cpu_ack          core read data (valid in the ack cycle, then held), ack pulse
//   host_*                      same set of signals for the host port
//   ram_addr/wdata/we           RAM macro controls
//   ram_rdata                   RAM read data (registered in the RAM, 1-cycle latency)
//   owner                       00 none, 01 core, 10 host (high during ACCESS)
//   stall_cnt                   saturating count of cycles with a waiting request
module mem_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_halted,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_HOST = 2'b10;

  state_t            state;
  logic              win_host;   // winner of the access in flight
  logic              lat_we;     // latched direction of the access in flight
  logic              last_host;  // round-robin history: host was served last
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic              cpu_elig;
  logic              host_elig;
  logic              grant;
  logic              grant_host;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cpu_stall;
  logic              host_stall;

  // Arbitration at the IDLE and RESPOND edges, plus stall detection.
  always_comb begin
    grant      = 1'b0;
    grant_host = 1'b0;
    // A halted core is never granted, so the host cannot be overtaken.
    cpu_elig   = cpu_req & ~cpu_halted;
    host_elig  = host_req;
    case (state)
      IDLE: begin
        grant      = cpu_elig | host_elig;
        grant_host = host_elig & (~cpu_elig | ~last_host);
      end
      RESPOND: begin
        // The requester being acked is ineligible; only the other may chain.
        grant      = win_host ? cpu_elig : host_elig;
        grant_host = ~win_host;
      end
      default: ;
    endcase
    sel_we     = grant_host ? host_we    : cpu_we;
    sel_addr   = grant_host ? host_addr  : cpu_addr;
    sel_wdata  = grant_host ? host_wdata : cpu_wdata;
    cpu_stall  = cpu_req  & ~((state != IDLE) & ~win_host) & ~(grant & ~grant_host);
    host_stall = host_req & ~((state != IDLE) &  win_host) & ~(grant &  grant_host);
  end

  // Access sequencer with registered RAM controls, acks and owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      win_host     <= 1'b0;
      lat_we       <= 1'b0;
      last_host    <= 1'b1;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_we       <= 1'b0;
      owner        <= OWN_NONE;
      cpu_ack      <= 1'b0;
      host_ack     <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      stall_cnt    <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      ram_we   <= 1'b0;
      owner    <= OWN_NONE;
      if ((cpu_stall | host_stall) && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        ACCESS: begin
          state <= RESPOND;
          if (win_host) host_ack <= 1'b1;
          else          cpu_ack  <= 1'b1;
        end
        default: begin
          if (state == RESPOND) begin
            last_host <= win_host;
            if (!lat_we) begin
              if (win_host) host_rdata_q <= ram_rdata;
              else          cpu_rdata_q  <= ram_rdata;
            end
          end
          if (grant) begin
            state     <= ACCESS;
            win_host  <= grant_host;
            lat_we    <= sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            ram_we    <= sel_we;
            owner     <= grant_host ? OWN_HOST : OWN_CPU;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // RAM data only appears in RESPOND, so it is forwarded in the ack cycle
  // while the hold register captures it for the following cycles.
  assign cpu_rdata  = (state == RESPOND && !lat_we && !win_host) ? ram_rdata : cpu_rdata_q;
  assign host_rdata = (state == RESPOND && !lat_we &&  win_host) ? ram_rdata : host_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural registered-output RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_halted = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [4:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_ack;
  logic [4:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata = '0;
  logic [1:0]  owner;
  logic [7:0]  stall_cnt;

  logic [15:0] mem [32] = '{default: 16'h0000};

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cpu_halted(cpu_halted),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .owner(owner), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        host;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic host, input logic req, input logic we,
                       input logic [4:0] a, input logic [15:0] wd);
    if (host) begin
      host_req = req; host_we = we; host_addr = a; host_wdata = wd;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single-requester transaction starting at a negedge in IDLE.
  task automatic do_txn(input vec_t v);
    logic [15:0] rd;
    drive(v.host, 1'b1, v.we, v.addr, v.wdata);
    cycle();
    chk("access_owner", 32'(owner), v.host ? 32'd2 : 32'd1);
    chk("access_addr", 32'(ram_addr), 32'(v.addr));
    chk("access_we", 32'(ram_we), 32'(v.we));
    if (v.we) chk("access_wdata", 32'(ram_wdata), 32'(v.wdata));
    // Scramble the request payload after the latch edge.
    drive(v.host, 1'b1, ~v.we, ~v.addr, ~v.wdata);
    cycle();
    chk("resp_cpu_ack", 32'(cpu_ack), v.host ? 32'd0 : 32'd1);
    chk("resp_host_ack", 32'(host_ack), v.host ? 32'd1 : 32'd0);
    chk("resp_ram_we", 32'(ram_we), 32'd0);
    chk("resp_owner", 32'(owner), 32'd0);
    rd = v.host ? host_rdata : cpu_rdata;
    if (!v.we) chk("resp_rdata", 32'(rd), 32'(v.rdata));
    drive(v.host, 1'b0, 1'b0, '0, '0);
    cycle();
    chk("idle_acks", 32'({cpu_ack, host_ack}), 32'd0);
    rd = v.host ? host_rdata : cpu_rdata;
    if (!v.we) chk("idle_rdata_hold", 32'(rd), 32'(v.rdata));
  endtask

  initial begin
    vecs[0] = '{host: 1'b1, we: 1'b1, addr: 5'd5,  wdata: 16'h1234, rdata: 16'h0000};
    vecs[1] = '{host: 1'b0, we: 1'b0, addr: 5'd5,  wdata: 16'h0000, rdata: 16'h1234};
    vecs[2] = '{host: 1'b0, we: 1'b1, addr: 5'd10, wdata: 16'hA5A5, rdata: 16'h0000};
    vecs[3] = '{host: 1'b1, we: 1'b0, addr: 5'd10, wdata: 16'h0000, rdata: 16'hA5A5};
    vecs[4] = '{host: 1'b1, we: 1'b1, addr: 5'd31, wdata: 16'hBEEF, rdata: 16'h0000};
    vecs[5] = '{host: 1'b0, we: 1'b0, addr: 5'd31, wdata: 16'h0000, rdata: 16'hBEEF};
    vecs[6] = '{host: 1'b0, we: 1'b1, addr: 5'd0,  wdata: 16'h0001, rdata: 16'h0000};
    vecs[7] = '{host: 1'b1, we: 1'b0, addr: 5'd0,  wdata: 16'h0000, rdata: 16'h0001};

    // Reset state
    repeat (2) cycle();
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_acks", 32'({cpu_ack, host_ack}), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_rdata", 32'({cpu_rdata, host_rdata}), 32'd0);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);
    chk("stall_after_singles", 32'(stall_cnt), 32'd0);

    // Simultaneous pair after reset history: core first, host back-to-back.
    drive(1'b0, 1'b1, 1'b0, 5'd5, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 5'd7, 16'h7777);
    cycle();
    chk("pair1_c1_owner", 32'(owner), 32'd1);
    cycle();
    chk("pair1_c2_cpu_ack", 32'({cpu_ack, host_ack}), 32'b10);
    chk("pair1_c2_rdata", 32'(cpu_rdata), 32'h1234);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    chk("pair1_c3_owner", 32'(owner), 32'd2);
    chk("pair1_c3_we", 32'(ram_we), 32'd1);
    chk("pair1_c3_addr", 32'(ram_addr), 32'd7);
    cycle();
    chk("pair1_c4_host_ack", 32'({cpu_ack, host_ack}), 32'b01);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    exp_stall += 2;
    chk("pair1_stall", 32'(stall_cnt), 32'(exp_stall));
    cycle();
    chk("pair1_idle_owner", 32'(owner), 32'd0);

    // Core-only access leaves the core as last owner; next tie goes to the host.
    do_txn(vecs[1]);
    drive(1'b0, 1'b1, 1'b0, 5'd7, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 5'd9, 16'h0909);
    cycle();
    chk("pair2_c1_owner", 32'(owner), 32'd2);
    cycle();
    chk("pair2_c2_host_ack", 32'({cpu_ack, host_ack}), 32'b01);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    cycle();
    chk("pair2_c3_owner", 32'(owner), 32'd1);
    cycle();
    chk("pair2_c4_cpu_ack", 32'({cpu_ack, host_ack}), 32'b10);
    chk("pair2_c4_rdata", 32'(cpu_rdata), 32'h7777);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    exp_stall += 2;
    chk("pair2_stall", 32'(stall_cnt), 32'(exp_stall));
    cycle();

    // Halt priority: host issues 3 writes, core waits throughout.
    cpu_halted = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 5'd1, 16'h1111);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      exp_stall++;
      @(negedge clk);
      chk("halt_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("halt_host_ack", 32'(host_ack), (n % 3 == 2) ? 32'd1 : 32'd0);
      chk("halt_stall", 32'(stall_cnt), 32'(exp_stall));
      if (n == 2) drive(1'b1, 1'b1, 1'b1, 5'd2, 16'h2222);
      if (n == 5) drive(1'b1, 1'b1, 1'b1, 5'd3, 16'h3333);
      if (n == 8) begin
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    cycle();
    cpu_halted = 1'b0;
    chk("halt_mem1", 32'(mem[1]), 32'h1111);
    chk("halt_mem2", 32'(mem[2]), 32'h2222);
    chk("halt_mem3", 32'(mem[3]), 32'h3333);
    chk("halt_stall_hold", 32'(stall_cnt), 32'(exp_stall));

    // Reset in the middle of a core write.
    drive(1'b0, 1'b1, 1'b1, 5'd12, 16'hDEAD);
    cycle();
    chk("mid_access_we", 32'(ram_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(ram_we), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    chk("mid_rst_ram", 32'({ram_addr, ram_wdata}), 32'd0);
    chk("mid_rst_rdata", 32'({cpu_rdata, host_rdata}), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    chk("mid_rst_no_ack", 32'({cpu_ack, host_ack}), 32'd0);
    chk("mid_rst_no_write", 32'(mem[12]), 32'h0000);
    rst_n = 1'b1;
    exp_stall = 0;
    drive(1'b0, 1'b1, 1'b0, 5'd31, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 16'h0);
    cycle();
    chk("post_rst_owner", 32'(owner), 32'd1);
    cycle();
    chk("post_rst_cpu_ack", 32'({cpu_ack, host_ack}), 32'b10);
    chk("post_rst_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    chk("post_rst_host_owner", 32'(owner), 32'd2);
    cycle();
    chk("post_rst_host_ack", 32'({cpu_ack, host_ack}), 32'b01);
    chk("post_rst_host_rdata", 32'(host_rdata), 32'h1234);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    exp_stall += 2;
    chk("post_rst_stall", 32'(stall_cnt), 32'(exp_stall));
    cycle();

    // Saturation: core held off by halt for 300 cycles.
    cpu_halted = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd4, 16'h0);
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      if (exp_stall < 255) exp_stall++;
      @(negedge clk);
      if (n == 200) chk("sat_mid", 32'(stall_cnt), 32'(exp_stall));
      if (cpu_ack) chk("sat_cpu_ack", 32'(cpu_ack), 32'd0);
    end
    chk("sat_final", 32'(stall_cnt), 32'(exp_stall));
    chk("sat_max", 32'(stall_cnt), 32'd255);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    cpu_halted = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
